alu: RTL and testbench
======================

# alu

Registered 32-bit integer ALU for the pipelined MIPS datapath. It sits in the EX stage and performs add, subtract, bitwise OR or signed compare on two operands selected by a 2-bit opcode. The result and status flags are captured in output registers one clock after the request is accepted.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width in bits.

Ports:
- `clk` input 1: single clock, rising-edge active.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: operands and opcode are valid this cycle.
- `A` input WIDTH: operand A.
- `B` input WIDTH: operand B.
- `ALUop` input 2: operation select.
- `C` output WIDTH: registered result.
- `out_valid` output 1: `C` and the flags hold a new result.
- `zero` output 1: registered; set when the result is all zeros.
- `overflow` output 1: registered signed-overflow flag for add and subtract.

## Operation
- `ALUop` encoding:
  - 00 ADD: C = A + B, modulo 2^WIDTH.
  - 01 SUB: C = A − B, modulo 2^WIDTH.
  - 10 OR: C = A | B.
  - 11 SLT: C = 1 if $signed(A) < $signed(B), else 0. Bits [WIDTH-1:1] are zero.
- The result is computed combinationally from A, B and ALUop. It is registered on the rising edge of `clk` when `in_valid` is 1.
- When `in_valid` is 0, C, zero and overflow hold their previous values, and out_valid is cleared to 0 on that edge.
- zero = (next C == 0). It is computed for every opcode.
- overflow:
  - ADD: A and B have the same sign and the sum sign differs from it.
  - SUB: A and B have different signs and the difference sign differs from A.
  - OR and SLT: overflow is 0.
- SLT compares correctly across the full signed range, including 0x80000000 vs 0x7FFFFFFF, by using the true sign of the difference, not the wrapped subtraction result.
- No exception or trap is generated. Overflow is a flag only and C always carries the wrapped result.
- X or unknown inputs while `in_valid` is 0 have no effect on any output.

## Timing
- Latency: exactly 1 cycle. A request accepted at edge N is visible on the outputs after edge N.
- Throughput: one operation per cycle. Back-to-back `in_valid` produces back-to-back `out_valid`.
- No backpressure exists. The consumer must take the result in the cycle `out_valid` is high.
- Reset (`rst_n` = 0) asynchronously forces C = 0, out_valid = 0, zero = 1 and overflow = 0, independent of `clk`.
- A reset asserted while a request is in flight discards that request. The first result after `rst_n` deasserts needs a fresh `in_valid`.
- Release of `rst_n` is synchronised by the system. The block samples inputs from the first rising edge after release.

## Configuration
- `ALU_OVF_EN` defined: overflow detection logic as specified above is compiled in.
- `ALU_OVF_EN` undefined: the overflow logic is omitted and `overflow` is tied to 0. All other behaviour is identical.

## Test plan
- Reset: drive rst_n = 0 mid-cycle -> C = 0, out_valid = 0, zero = 1, overflow = 0 immediately, without a clock edge.
- Basic ops with A = 1, B = 2, one per cycle:
  - ALUop 00 -> C = 3.
  - ALUop 01 -> C = 0xFFFFFFFF.
  - ALUop 10 -> C = 3.
  - ALUop 11 -> C = 1.
  - Each result appears one cycle after its request.
- Compare and zero: A = 1, B = 1, ALUop 11 -> C = 0, zero = 1. Then ALUop 01 -> C = 0, zero = 1.
- Signed boundaries:
  - ADD 0x7FFFFFFF + 1 -> C = 0x80000000, overflow = 1 (0 when `ALU_OVF_EN` is undefined).
  - SUB 0x80000000 − 1 -> C = 0x7FFFFFFF, overflow = 1.
  - SLT A = 0x80000000, B = 0x7FFFFFFF -> C = 1.
- Hold: issue one request, then drop in_valid for 3 cycles -> out_valid = 0 during those cycles and C keeps the last value.
- Streaming: 8 consecutive random requests -> 8 consecutive out_valid pulses, each C matching the reference model of the request one cycle earlier.

Source files
------------

// File: rtl/alu.sv
// ============================================================================
// Module   : alu
// Brief    : Registered 32-bit EX-stage ALU (ADD/SUB/OR/SLT) with zero and
//            signed-overflow flags; overflow logic enabled by `ALU_OVF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ALUop,
  output logic [WIDTH-1:0] C,
  output logic             out_valid,
  output logic             zero,
  output logic             overflow
);

  localparam logic [1:0] c_OP_ADD = 2'b00;
  localparam logic [1:0] c_OP_SUB = 2'b01;
  localparam logic [1:0] c_OP_OR  = 2'b10;
  localparam logic [1:0] c_OP_SLT = 2'b11;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH:0]   w_diff_ext;
  logic             w_slt;
  logic [WIDTH-1:0] w_result;
  logic             w_ovf;

  assign w_sum  = A + B;
  assign w_diff = A - B;

  // One extra sign bit keeps the difference exact, so its MSB is the true sign.
  assign w_diff_ext = {A[WIDTH-1], A} - {B[WIDTH-1], B};
  assign w_slt      = w_diff_ext[WIDTH];

  always_comb begin
    w_result = '0;
    case (ALUop)
      c_OP_ADD: w_result = w_sum;
      c_OP_SUB: w_result = w_diff;
      c_OP_OR:  w_result = A | B;
      c_OP_SLT: w_result = {{(WIDTH-1){1'b0}}, w_slt};
      default:  w_result = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  always_comb begin
    w_ovf = 1'b0;
    case (ALUop)
      c_OP_ADD: w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      c_OP_SUB: w_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      default:  w_ovf = 1'b0;
    endcase
  end
`else
  assign w_ovf = 1'b0;
`endif

  // Result registers only load on accepted requests; out_valid is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      C         <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        C        <= w_result;
        zero     <= (w_result == '0);
        overflow <= w_ovf;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ============================================================================
// Module   : tb_alu
// Brief    : Self-checking bench for alu against an arithmetic reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       ALUop;
  logic [WIDTH-1:0] C;
  logic             out_valid;
  logic             zero;
  logic             overflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] exp_c;
  logic             exp_v;
  logic             exp_z;
  logic             exp_ov;

  alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .ALUop     (ALUop),
    .C         (C),
    .out_valid (out_valid),
    .zero      (zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: signed math in 64 bits, wrap and range-test afterwards.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       output logic [31:0] c, output logic ov);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ov = 1'b0;
    c  = '0;
    case (op)
      2'd0: begin r = sa + sb; c = r[31:0]; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      2'd1: begin r = sa - sb; c = r[31:0]; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      2'd2: c = a | b;
      default: c = (sa < sb) ? 32'd1 : 32'd0;
    endcase
`ifndef ALU_OVF_EN
    ov = 1'b0;
`endif
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".C"},   {32'd0, C},   {32'd0, exp_c});
    chk({tag, ".vld"}, {63'd0, out_valid}, {63'd0, exp_v});
    chk({tag, ".z"},   {63'd0, zero},      {63'd0, exp_z});
    chk({tag, ".ovf"}, {63'd0, overflow},  {63'd0, exp_ov});
  endtask

  // Drive one cycle of stimulus, then check outputs 1 time unit after the edge.
  task automatic step(input string tag, input logic v, input logic [31:0] a,
                      input logic [31:0] b, input logic [1:0] op);
    logic [31:0] c;
    logic        ov;
    in_valid = v;
    A        = a;
    B        = b;
    ALUop    = op;
    @(posedge clk);
    #1;
    if (v) begin
      model(a, b, op, c, ov);
      exp_c  = c;
      exp_z  = (c == 32'd0);
      exp_ov = ov;
    end
    exp_v = v;
    check_outs(tag);
  endtask

  function automatic logic [31:0] corner(input int k);
    case (k)
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  logic exp_add_ovf;
  logic [31:0] held_c;

  initial begin
`ifdef ALU_OVF_EN
    exp_add_ovf = 1'b1;
`else
    exp_add_ovf = 1'b0;
`endif
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; ALUop = 2'd0;
    exp_c = '0; exp_v = 1'b0; exp_z = 1'b1; exp_ov = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Load a non-reset state, then assert reset mid-cycle with a request pending.
    step("pre_rst", 1'b1, 32'h7FFF_FFFF, 32'd1, 2'd0);
    in_valid = 1'b1; A = 32'd5; B = 32'd6; ALUop = 2'd2;
    #3;
    rst_n = 1'b0;
    #1;
    exp_c = '0; exp_v = 1'b0; exp_z = 1'b1; exp_ov = 1'b0;
    check_outs("async_rst");
    @(posedge clk);
    #1;
    check_outs("rst_hold");
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b0, 32'd9, 32'd9, 2'd0);

    // Basic ops with A=1, B=2.
    step("add12", 1'b1, 32'd1, 32'd2, 2'd0); chk("add12.lit", {32'd0, C}, 64'd3);
    step("sub12", 1'b1, 32'd1, 32'd2, 2'd1); chk("sub12.lit", {32'd0, C}, 64'hFFFF_FFFF);
    step("or12",  1'b1, 32'd1, 32'd2, 2'd2); chk("or12.lit",  {32'd0, C}, 64'd3);
    step("slt12", 1'b1, 32'd1, 32'd2, 2'd3); chk("slt12.lit", {32'd0, C}, 64'd1);

    // Compare-equal and zero flag.
    step("slt11", 1'b1, 32'd1, 32'd1, 2'd3);
    chk("slt11.lit", {32'd0, C}, 64'd0); chk("slt11.zlit", {63'd0, zero}, 64'd1);
    step("sub11", 1'b1, 32'd1, 32'd1, 2'd1);
    chk("sub11.lit", {32'd0, C}, 64'd0); chk("sub11.zlit", {63'd0, zero}, 64'd1);

    // Signed boundaries.
    step("add_ovf", 1'b1, 32'h7FFF_FFFF, 32'd1, 2'd0);
    chk("add_ovf.lit", {32'd0, C}, 64'h8000_0000);
    chk("add_ovf.flit", {63'd0, overflow}, {63'd0, exp_add_ovf});
    step("sub_ovf", 1'b1, 32'h8000_0000, 32'd1, 2'd1);
    chk("sub_ovf.lit", {32'd0, C}, 64'h7FFF_FFFF);
    chk("sub_ovf.flit", {63'd0, overflow}, {63'd0, exp_add_ovf});
    step("slt_min", 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 2'd3);
    chk("slt_min.lit", {32'd0, C}, 64'd1);
    step("slt_max", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 2'd3);
    chk("slt_max.lit", {32'd0, C}, 64'd0);

    // Hold: outputs frozen while idle, inputs are junk.
    step("hold_req", 1'b1, 32'h1234_5678, 32'h0F0F_0000, 2'd2);
    held_c = C;
    for (int i = 0; i < 3; i++) begin
      step("hold", 1'b0, $urandom, $urandom, 2'($urandom_range(0, 3)));
      chk("hold.lit", {32'd0, C}, {32'd0, held_c});
    end

    // Streaming: 8 back-to-back random requests.
    for (int i = 0; i < 8; i++)
      step("stream", 1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)));

    // Random traffic with corner operands and idle gaps.
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 3) != 0), corner($urandom_range(0, 7)),
           corner($urandom_range(0, 7)), 2'($urandom_range(0, 3)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
